// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults for the FIFO stream reader.
// FIFO flavour read latencies and sizing helpers.
package fifo_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_BUF_DEPTH  = 4;

  typedef enum logic [0:0] {
    FIFO_SRLC = 1'b0,
    FIFO_BRAM = 1'b1
  } fifo_kind_e;

  localparam int LAT_SRLC = 1;
  localparam int LAT_BRAM = 2;

  // Pointer/count width: one extra bit so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int read_lat(input fifo_kind_e k);
    return (k == FIFO_BRAM) ? LAT_BRAM : LAT_SRLC;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_fwft_buf.sv
// First-word-fall-through register-array buffer.
// Head word is visible whenever the buffer is not empty.
module fifo_stream_reader_fwft_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_BUF_DEPTH,
  parameter int CW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [CW-1:0] wr_q;
  logic [CW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; indices wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + CW'(1);
      end
      if (pop_i) rd_q <= rd_q + CW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fixed-latency FIFO into a valid/ready stream.
// Credit-limited reads, latency pipe and burst framing.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_LAT   = LAT_SRLC,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = ptr_w(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + READ_LAT + 1) + 1;

  logic [READ_LAT-1:0]  pipe_q;
  logic [READ_LAT-1:0]  pipe_d;
  logic [OW-1:0]        inflight;
  logic [OW-1:0]        occ;
  logic [OW-1:0]        occ_net;
  logic [CW-1:0]        buf_cnt;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_push;
  logic                 pop;
  logic                 cap;

  logic [LEN_WIDTH-1:0] beat_q;
  logic [LEN_WIDTH-1:0] beat_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] len_d;
  logic [LEN_WIDTH-1:0] len_eff;
  logic                 armed_q;
  logic                 armed_d;

  assign cap      = pipe_q[READ_LAT-1];
  assign pop      = m_valid && m_ready;
  assign buf_push = cap && (!buf_full || pop);

  // Count reads still travelling through the FIFO output pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++)
      inflight = inflight + OW'(pipe_q[i]);
  end

  assign occ     = OW'(buf_cnt) + inflight;
  assign occ_net = occ - OW'(pop);
  assign fifo_rd_en = !fifo_empty && !rst &&
                      (occ_net < OW'(BUF_DEPTH));
  assign busy    = (occ != '0);
  assign pipe_d  = READ_LAT'({pipe_q, fifo_rd_en});

  // Valid pipe: a bit leaves the top exactly when fifo_data is live.
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  fifo_stream_reader_fwft_buf #(
    .DW    (DATA_WIDTH),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (buf_push),
    .din_i   (fifo_data),
    .pop_i   (pop),
    .dout_o  (m_data),
    .empty_o (buf_empty),
    .full_o  (buf_full),
    .count_o (buf_cnt)
  );

  assign m_valid = !buf_empty;

  // First beat uses the live length until it is latched, so a
  // zero-length burst marks its very first word as last.
  assign len_eff = (beat_q == '0 && !armed_q) ? cfg_burst_len
                                              : len_q;
  assign m_last  = m_valid && (beat_q == len_eff);

  // Burst state: latch length once per burst, wrap after the last beat.
  always_comb begin
    beat_d  = beat_q;
    len_d   = len_q;
    armed_d = armed_q;
    if (m_valid && beat_q == '0 && !armed_q) len_d = cfg_burst_len;
    if (pop) begin
      armed_d = 1'b0;
      beat_d  = m_last ? '0 : beat_q + LEN_WIDTH'(1);
    end else if (m_valid && beat_q == '0) begin
      armed_d = 1'b1;
    end
  end

  // Burst counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      len_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      len_q   <= len_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader.
// Two instances: SRLC-style (latency 1) and BRAM-style (latency 2).
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  // ---- instance A: READ_LAT=1 ----
  logic        rst_a, fe_a, rd_a, mv_a, mr_a, ml_a, busy_a;
  logic [63:0] fd_a, md_a;
  logic [7:0]  cfg_a;
  logic [63:0] mem_a [4096];
  logic [11:0] wp_a = '0;
  logic [11:0] rp_a = '0;
  int          viol_a = 0;
  int          rdn_a = 0;

  assign fe_a = (wp_a == rp_a);

  fifo_stream_reader #(
    .DATA_WIDTH(64), .READ_LAT(1),
    .BUF_DEPTH(4), .LEN_WIDTH(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .fifo_empty(fe_a),
    .fifo_rd_en(rd_a), .fifo_data(fd_a),
    .cfg_burst_len(cfg_a), .m_valid(mv_a),
    .m_ready(mr_a), .m_data(md_a), .m_last(ml_a),
    .busy(busy_a)
  );

  always @(posedge clk) begin
    if (rst_a) rp_a <= wp_a;
    else if (rd_a) begin
      fd_a <= mem_a[rp_a];
      rp_a <= rp_a + 12'd1;
      rdn_a <= rdn_a + 1;
      if (fe_a) viol_a <= viol_a + 1;
    end
  end

  logic [63:0] ga_d [$];
  logic        ga_l [$];
  int          ga_c [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_a && mv_a && mr_a) begin
      ga_d.push_back(md_a);
      ga_l.push_back(ml_a);
      ga_c.push_back(cyc);
    end
  end

  // ---- instance B: READ_LAT=2 ----
  logic        rst_b, fe_b, rd_b, mv_b, mr_b, ml_b, busy_b;
  logic [63:0] fd1_b, fd_b, md_b;
  logic [7:0]  cfg_b;
  logic [63:0] mem_b [4096];
  logic [11:0] wp_b = '0;
  logic [11:0] rp_b = '0;
  int          viol_b = 0;
  int          rdn_b = 0;
  int          acc_b = 0;
  int          maxocc_b = 0;

  assign fe_b = (wp_b == rp_b);

  fifo_stream_reader #(
    .DATA_WIDTH(64), .READ_LAT(2),
    .BUF_DEPTH(4), .LEN_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .fifo_empty(fe_b),
    .fifo_rd_en(rd_b), .fifo_data(fd_b),
    .cfg_burst_len(cfg_b), .m_valid(mv_b),
    .m_ready(mr_b), .m_data(md_b), .m_last(ml_b),
    .busy(busy_b)
  );

  logic [63:0] gb_d [$];
  logic        gb_l [$];

  always @(posedge clk) begin
    fd_b <= fd1_b;
    if (rst_b) begin
      rp_b  <= wp_b;
      rdn_b <= 0;
      acc_b <= 0;
    end else begin
      if ((rdn_b - acc_b) > maxocc_b) maxocc_b <= rdn_b - acc_b;
      if (rd_b) begin
        fd1_b <= mem_b[rp_b];
        rp_b  <= rp_b + 12'd1;
        rdn_b <= rdn_b + 1;
        if (fe_b) viol_b <= viol_b + 1;
      end
      if (mv_b && mr_b) begin
        acc_b <= acc_b + 1;
        gb_d.push_back(md_b);
        gb_l.push_back(ml_b);
      end
    end
  end

  // ---- helpers ----
  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [63:0] w);
    mem_a[wp_a] = w;
    wp_a = wp_a + 12'd1;
  endtask

  task automatic push_b(input logic [63:0] w);
    mem_b[wp_b] = w;
    wp_b = wp_b + 12'd1;
  endtask

  task automatic wait_a(input int n);
    for (int k = 0; k < 60 && ga_d.size() < n; k++) tick(1);
  endtask

  int base;
  int r0;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    mr_a = 1'b0;  mr_b = 1'b0;
    cfg_a = 8'd3; cfg_b = 8'd4;
    tick(2);
    chk("rst_mvalid_a", mv_a, 0);
    chk("rst_mlast_a", ml_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_rden_a", rd_a, 0);
    chk("rst_mdata_a", md_a, 0);
    chk("rst_mvalid_b", mv_b, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1);
    chk("idle_rden_a", rd_a, 0);

    // full-rate drain, len=3
    mr_a = 1'b1;
    base = ga_d.size();
    for (int i = 0; i < 8; i++) push_a(64'h10 + 64'(i));
    wait_a(base + 8);
    chk("t1_count", 64'(ga_d.size() - base), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", ga_d[base+i], 64'h10 + 64'(i));
      chk("t1_last", ga_l[base+i], (i % 4) == 3);
    end
    chk("t1_backtoback", 64'(ga_c[base+7] - ga_c[base]), 7);

    // back-pressure with 6 words queued
    mr_a = 1'b0;
    r0 = rdn_a;
    base = ga_d.size();
    for (int i = 0; i < 6; i++) push_a(64'h20 + 64'(i));
    tick(2);
    chk("t2_head_early", md_a, 64'h20);
    chk("t2_valid", mv_a, 1);
    tick(8);
    chk("t2_reads", 64'(rdn_a - r0), 4);
    chk("t2_head_held", md_a, 64'h20);
    chk("t2_last_held", ml_a, 0);
    chk("t2_rden_stop", rd_a, 0);
    chk("t2_busy", busy_a, 1);
    mr_a = 1'b1;
    wait_a(base + 6);
    chk("t2_count", 64'(ga_d.size() - base), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_data", ga_d[base+i], 64'h20 + 64'(i));
      chk("t2_last", ga_l[base+i], i == 3);
    end

    // empty mid-stream; burst position is beat 2
    base = ga_d.size();
    push_a(64'h30); push_a(64'h31);
    tick(4);
    chk("t3_gap_valid", mv_a, 0);
    chk("t3_gap_busy", busy_a, 0);
    tick(1);
    for (int i = 2; i < 6; i++) push_a(64'h30 + 64'(i));
    wait_a(base + 6);
    chk("t3_count", 64'(ga_d.size() - base), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_data", ga_d[base+i], 64'h30 + 64'(i));
      chk("t3_last", ga_l[base+i], i == 1 || i == 5);
    end
    chk("t3_gap_seen", 64'(ga_c[base+2] - ga_c[base+1] > 1), 1);

    // length change at beat 2 of a burst
    base = ga_d.size();
    for (int i = 0; i < 8; i++) push_a(64'h40 + 64'(i));
    wait_a(base + 2);
    cfg_a = 8'd1;
    wait_a(base + 8);
    chk("t4_count", 64'(ga_d.size() - base), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t4_data", ga_d[base+i], 64'h40 + 64'(i));
      chk("t4_last", ga_l[base+i], i == 3 || i == 5 || i == 7);
    end

    // reset with a full buffer
    mr_a = 1'b0;
    for (int i = 0; i < 6; i++) push_a(64'h50 + 64'(i));
    tick(8);
    chk("t5_pre_busy", busy_a, 1);
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    chk("t5_mvalid", mv_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_rden", rd_a, 0);
    base = ga_d.size();
    mr_a = 1'b1;
    tick(6);
    chk("t5_no_stale", 64'(ga_d.size() - base), 0);
    push_a(64'h60); push_a(64'h61);
    wait_a(base + 2);
    chk("t5_d0", ga_d[base], 64'h60);
    chk("t5_d1", ga_d[base+1], 64'h61);
    chk("t5_l0", ga_l[base], 0);
    chk("t5_l1", ga_l[base+1], 1);
    chk("a_rd_while_empty", 64'(viol_a), 0);

    // latency-2 reset with 2 in flight and 2 buffered
    for (int i = 0; i < 6; i++) push_b(64'hB0 + 64'(i));
    tick(4);
    chk("t6_pre_busy", busy_b, 1);
    chk("t6_pre_valid", mv_b, 1);
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    chk("t6_mvalid", mv_b, 0);
    chk("t6_busy", busy_b, 0);
    chk("t6_rden", rd_b, 0);
    tick(6);
    chk("t6_no_stale", mv_b, 0);

    // latency-2 random back-pressure, 1000 words, len=4
    base = gb_d.size();
    for (int i = 0; i < 1000; i++)
      push_b(64'hC0DE_0000_0000_0000 | 64'(i));
    for (int k = 0; k < 20000 && gb_d.size() < base + 1000; k++) begin
      mr_b = 1'($urandom_range(0, 1));
      tick(1);
    end
    mr_b = 1'b0;
    chk("t7_count", 64'(gb_d.size() - base), 1000);
    for (int i = 0; i < 1000; i++) begin
      chk("t7_data", gb_d[base+i], 64'hC0DE_0000_0000_0000 | 64'(i));
      chk("t7_last", gb_l[base+i], (i % 5) == 4);
    end
    chk("t7_occ_max", 64'(maxocc_b <= 4), 1);
    chk("b_rd_while_empty", 64'(viol_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
